// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch controller: FSM state
// encoding and the instruction constants used by loader, fetch logic and bench.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // beq x0,x0,0 -- a branch onto itself, used as the program terminator
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h00000063;
  localparam logic [31:0] NOP_INSTR         = 32'h00000013;

endpackage

// File: rtl/imem_byte_loader.sv
// Byte-stream program loader: counts accepted bytes and drives the memory byte
// write port; bytes beyond the memory size are accepted but flagged, not written.
module imem_byte_loader
  import imem_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        accept,
  output logic        overflow,
  output logic        mem_we,
  output logic [63:0] mem_waddr,
  output logic [7:0]  mem_wdata
);

  logic [63:0] count_reg;
  logic        in_range;

  // Reset masks the port so nothing reaches memory while reset is held.
  assign ld_ready  = load_en && !reset;
  assign accept    = ld_ready && ld_valid;
  assign in_range  = count_reg < 64'(MEM_BYTES);
  assign mem_we    = accept && in_range;
  assign overflow  = accept && !in_range;
  assign mem_waddr = count_reg;
  assign mem_wdata = ld_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + 64'd1;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: LOAD/RUN/HALT FSM plus the fetch output
// register. Define IMEM_FETCH_HALT_DETECT_EN to halt on a handshaken HALT_WORD.
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          MEM_BYTES = 256,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        mem_we,
  output logic [63:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic [63:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  input  logic        redir_valid,
  input  logic [63:0] redir_pc,
  output logic [1:0]  state,
  output logic        err
);

  localparam logic [63:0] LAST_WORD_ADDR = 64'(MEM_BYTES - 4);

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [63:0] if_pc_reg, if_pc_next;
  logic        err_reg, err_next;
  logic        ld_accept, ld_overflow;
  logic        fetch_go, halt_match, halt_hit;

  imem_byte_loader #(.MEM_BYTES(MEM_BYTES)) u_loader (
    .clk       (clk),
    .reset     (reset),
    .load_en   (state_reg == LOAD),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_ready  (ld_ready),
    .accept    (ld_accept),
    .overflow  (ld_overflow),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  assign fetch_go   = !if_valid_reg || if_ready;
  assign halt_match = (if_instr_reg == HALT_WORD);
`ifdef IMEM_FETCH_HALT_DETECT_EN
  assign halt_hit = if_valid_reg && if_ready && halt_match;
`else
  // Comparison is kept but masked so HALT_WORD stays live in both builds.
  assign halt_hit = halt_match & 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    if_valid_next = if_valid_reg;
    if_instr_next = if_instr_reg;
    if_pc_next    = if_pc_reg;
    err_next      = err_reg;
    case (state_reg)
      LOAD: begin
        if (ld_overflow) err_next = 1'b1;
        if (ld_accept && ld_last) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        if (halt_hit) begin
          state_next    = HALT;
          if_valid_next = 1'b0;
        end else if (redir_valid) begin
          pc_next       = {redir_pc[63:2], 2'b00};
          if_valid_next = 1'b0;
          if (redir_pc[1:0] != 2'b00) err_next = 1'b1;
        end else if (fetch_go) begin
          if (pc_reg > LAST_WORD_ADDR) begin
            // Running off the end of memory: stop rather than fetch garbage.
            err_next      = 1'b1;
            state_next    = HALT;
            if_valid_next = 1'b0;
          end else begin
            if_instr_next = mem_rdata;
            if_pc_next    = pc_reg;
            if_valid_next = 1'b1;
            pc_next       = pc_reg + 64'd4;
          end
        end
      end
      default: begin
        if_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LOAD;
      pc_reg       <= '0;
      if_valid_reg <= 1'b0;
      if_instr_reg <= '0;
      if_pc_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      if_valid_reg <= if_valid_next;
      if_instr_reg <= if_instr_next;
      if_pc_reg    <= if_pc_next;
      err_reg      <= err_next;
    end
  end

  assign mem_raddr = pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_instr  = if_instr_reg;
  assign if_pc     = if_pc_reg;
  assign state     = state_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: byte-array memory model, randomized
// ready/redirect traffic and a fetch-stream reference model.
module tb_imem_fetch_ctrl;

  localparam int MEM = 128;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        mem_we;
  logic [63:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic [63:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic [1:0]  state;
  logic        err;

  imem_fetch_ctrl #(.MEM_BYTES(MEM), .HALT_WORD(32'h00000063)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .state       (state),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Instruction memory the DUT writes and reads.
  logic [7:0] tb_mem [MEM];
  always @(posedge clk) begin
    if (mem_we && mem_waddr < 64'(MEM)) tb_mem[int'(mem_waddr)] <= mem_wdata;
  end
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_raddr <= 64'(MEM - 4))
      mem_rdata = {tb_mem[int'(mem_raddr) + 3], tb_mem[int'(mem_raddr) + 2],
                   tb_mem[int'(mem_raddr) + 1], tb_mem[int'(mem_raddr)]};
  end

  // Reference model: memory image built from the bytes sent, plus fetch state.
  logic [7:0]  ref_mem [MEM];
  logic [7:0]  prog [512];
  int          n_checks = 0;
  int          n_fail = 0;
  int          load_cnt;
  logic [63:0] exp_pc, halt_pc;
  bit          exp_valid, exp_err, exp_halt;

  function automatic logic [31:0] ref_word(input logic [63:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i + 3], ref_mem[i + 2], ref_mem[i + 1], ref_mem[i]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1; ld_valid = 1'($urandom); ld_last = 1'($urandom);
    redir_valid = 1'($urandom); redir_pc = 64'($urandom); if_ready = 1'($urandom);
    #1;
    check("we_in_reset", mem_we, 0);
    @(posedge clk); #1;
    reset = 0; ld_valid = 0; ld_last = 0; redir_valid = 0; if_ready = 0;
    #1;
    check("rst_state", state, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_err", err, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_we", mem_we, 0);
    exp_err = 0; exp_halt = 0; exp_valid = 0; exp_pc = 0; load_cnt = 0;
    $display("reset applied");
  endtask

  task automatic load_bytes(input int n, input bit send_last, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        ld_valid = 0; #1;
        check("we_idle", mem_we, 0);
        check("ld_ready_idle", ld_ready, 1);
        @(posedge clk); #1;
      end
      ld_valid = 1; ld_byte = prog[i]; ld_last = send_last && (i == n - 1);
      #1;
      check("ld_ready", ld_ready, 1);
      if (load_cnt < MEM) begin
        check("we", mem_we, 1);
        check("waddr", mem_waddr, 64'(load_cnt));
        check("wdata", mem_wdata, prog[i]);
        ref_mem[load_cnt] = prog[i];
      end else begin
        check("we_over", mem_we, 0);
        exp_err = 1;
      end
      $display("load byte %0d = %h", load_cnt, prog[i]);
      load_cnt++;
      @(posedge clk); #1;
      ld_valid = 0; ld_last = 0;
      check("err_load", err, exp_err);
      if (!(send_last && i == n - 1)) check("state_load", state, 0);
    end
    if (send_last) begin
      check("state_run", state, 1);
      check("if_valid_n1", if_valid, 0);
      exp_pc = 0; exp_valid = 0; exp_halt = 0;
    end
  endtask

  task automatic drive_cycle(input bit rdy, input bit rv, input logic [63:0] rpc);
    logic [63:0] fpc;
    bit hs, hw;
    if_ready = rdy; redir_valid = rv; redir_pc = rpc;
    ld_valid = 1'($urandom); ld_byte = 8'($urandom); ld_last = 1'($urandom);
    #1;
    check("ld_ready_run", ld_ready, 0);
    check("we_run", mem_we, 0);
    if (exp_halt) begin
      check("halt_state", state, 2);
      check("halt_if_valid", if_valid, 0);
      check("halt_pc", mem_raddr, halt_pc);
    end else begin
      check("if_valid", if_valid, exp_valid);
      check("raddr", mem_raddr, exp_valid ? exp_pc + 64'd4 : exp_pc);
      if (exp_valid) begin
        check("if_pc", if_pc, exp_pc);
        check("if_instr", if_instr, ref_word(exp_pc));
      end
      hs = exp_valid && rdy && !rv;
      hw = 0;
      if (hs) $display("fetch pc=%h instr=%h", exp_pc, ref_word(exp_pc));
`ifdef IMEM_FETCH_HALT_DETECT_EN
      hw = hs && (ref_word(exp_pc) == 32'h00000063);
`endif
      if (rv) begin
        exp_pc = {rpc[63:2], 2'b00};
        if (rpc[1:0] != 2'b00) exp_err = 1;
        exp_valid = 0;
      end else if (!exp_valid || rdy) begin
        fpc = hs ? exp_pc + 64'd4 : exp_pc;
        if (hw) begin
          exp_halt = 1; halt_pc = fpc; exp_valid = 0;
        end else if (fpc > 64'(MEM - 4)) begin
          exp_halt = 1; exp_err = 1; halt_pc = fpc; exp_valid = 0;
        end else begin
          exp_pc = fpc; exp_valid = 1;
        end
      end
    end
    @(posedge clk); #1;
    check("err", err, exp_err);
  endtask

  task automatic random_run(input int n);
    int r;
    logic [63:0] rpc;
    for (int k = 0; k < n; k++) begin
      if (($urandom % 100) < 8) begin
        r = int'($urandom % 20);
        if (r == 0) rpc = 64'(MEM);
        else rpc = 64'($urandom_range(0, MEM / 4 - 1) * 4 + ((r == 1) ? $urandom_range(1, 3) : 0));
        drive_cycle(0, 1, rpc);
      end else begin
        drive_cycle(($urandom % 100) < 60, 0, 64'd0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wd;
    clk = 0; reset = 1; ld_valid = 0; ld_byte = 0; ld_last = 0;
    if_ready = 0; redir_valid = 0; redir_pc = 0;
    for (int i = 0; i < MEM; i++) begin tb_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    @(posedge clk); #1;
    do_reset();

    // Directed program: two instructions, hold, aligned and misaligned redirect.
    prog[0] = 8'h93; prog[1] = 8'h02; prog[2] = 8'h90; prog[3] = 8'h01;
    prog[4] = 8'h13; prog[5] = 8'h00; prog[6] = 8'h00; prog[7] = 8'h00;
    load_bytes(8, 1, 0);
    drive_cycle(1, 0, 0);
    check("first_valid_n2", if_valid, 1);
    check("first_instr", if_instr, 32'h01900293);
    check("first_pc", if_pc, 0);
    drive_cycle(1, 0, 0);
    check("second_instr", if_instr, 32'h00000013);
    check("second_pc", if_pc, 4);
    drive_cycle(1, 0, 0);
    repeat (3) drive_cycle(0, 0, 0);
    check("held_pc", if_pc, 8);
    drive_cycle(0, 1, 64'h20);
    check("flushed", if_valid, 0);
    drive_cycle(1, 0, 0);
    check("redir_pc", if_pc, 64'h20);
    drive_cycle(0, 1, 64'h22);
    check("misalign_err", err, 1);
    drive_cycle(1, 0, 0);
    check("misalign_pc", if_pc, 64'h20);
    random_run(200);

    // Reset mid-run, partial load, reset mid-load, then a fresh random program.
    do_reset();
    for (int i = 0; i < 512; i++) prog[i] = 8'($urandom);
    load_bytes(10, 0, 2);
    do_reset();
    for (int i = 0; i < 512; i++) prog[i] = 8'($urandom);
    load_bytes(24, 1, 2);
    random_run(300);

    // Overflowing load: extra bytes dropped, err set, RUN still entered.
    do_reset();
    for (int i = 0; i < 512; i++) prog[i] = 8'($urandom);
    load_bytes(MEM + 3, 1, 0);
    check("overflow_err", err, 1);
    random_run(100);

    // NOP program terminated by the halt word at the last memory word.
    do_reset();
    for (int w = 0; w < MEM / 4; w++) begin
      wd = (w == MEM / 4 - 1) ? 32'h00000063 : 32'h00000013;
      for (int b = 0; b < 4; b++) prog[4 * w + b] = wd[8 * b +: 8];
    end
    load_bytes(MEM, 1, 0);
    repeat (MEM / 4 + 6) drive_cycle(1, 0, 0);
    check("end_state", state, 2);
    check("end_if_valid", if_valid, 0);
    random_run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
